// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Purpose  : Accumulates a programmed number of unsigned PW-bit products,
//            delivered over a valid/ready handshake, into an SW-bit sum
//            (dot product). Signals completion with a one-cycle Done pulse
//            and holds Sum until the next job is started.
// Options  : PRODUCT_ACC_SATURATE_EN - when defined, the sum clamps at
//            2^SW-1 and a sticky per-job Overflow flag is raised. When
//            undefined, the sum wraps modulo 2^SW and Overflow is constant 0.
// Ports    : clk        system clock, rising edge
//            rst        asynchronous active-high reset
//            Start      start a job (sampled only in IDLE)
//            Count      number of products for the job (sampled with Start)
//            InValid    InProduct is valid
//            InProduct  unsigned product
//            InReady    a product is accepted this cycle
//            Sum        accumulated result
//            Done       one-cycle pulse, Sum is final
//            Busy       job in progress
//            Overflow   sticky saturation flag for the current job
// Revision : 1.0 - initial release
// ============================================================================
module product_accumulator #(
  parameter int PW = 16,
  parameter int SW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic [7:0]    Count,
  input  logic          InValid,
  input  logic [PW-1:0] InProduct,
  output logic          InReady,
  output logic [SW-1:0] Sum,
  output logic          Done,
  output logic          Busy,
  output logic          Overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [7:0]    r_remaining;
  logic [SW-1:0] r_sum;
  logic          r_overflow;

  logic          w_xfer;
  logic          w_last;
  logic [SW:0]   w_sum_ext;

  // Handshake and status outputs are pure decodes of the registered state,
  // so no input ever reaches an output combinationally.
  assign InReady = (r_state == S_ACCUM);
  assign Done    = (r_state == S_DONE);
  assign Busy    = (r_state != S_IDLE);
  assign Sum     = r_sum;

  assign w_xfer    = InValid && (r_state == S_ACCUM);
  assign w_last    = (r_remaining == 8'd1);
  // One extra bit keeps the carry so saturation can detect it.
  assign w_sum_ext = {1'b0, r_sum} + {{(SW + 1 - PW){1'b0}}, InProduct};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= 8'd0;
      r_sum       <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_sum       <= '0;
            r_overflow  <= 1'b0;
            r_remaining <= Count;
            r_state     <= (Count == 8'd0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_xfer) begin
`ifdef PRODUCT_ACC_SATURATE_EN
            if (w_sum_ext[SW]) begin
              r_sum      <= '1;
              r_overflow <= 1'b1;
            end else begin
              r_sum <= w_sum_ext[SW-1:0];
            end
`else
            r_sum <= w_sum_ext[SW-1:0];
`endif
            r_remaining <= r_remaining - 8'd1;
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PRODUCT_ACC_SATURATE_EN
  assign Overflow = r_overflow;
`else
  assign Overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_accumulator
// Purpose  : Self-checking bench for product_accumulator. Two instances share
//            the stimulus: the default-width one (SW=24) carries the
//            scoreboarded job results, the narrow one (SW=18) exercises the
//            wrap/saturation boundary.
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [7:0]  Count;
  logic        InValid;
  logic [15:0] InProduct;

  logic        a_ready, a_done, a_busy, a_ovf;
  logic [23:0] a_sum;
  logic        b_ready, b_done, b_busy, b_ovf;
  logic [17:0] b_sum;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] sb[$];

  product_accumulator #(.PW(16), .SW(24)) u_dut_a (
    .clk(clk), .rst(rst), .Start(Start), .Count(Count),
    .InValid(InValid), .InProduct(InProduct), .InReady(a_ready),
    .Sum(a_sum), .Done(a_done), .Busy(a_busy), .Overflow(a_ovf)
  );

  product_accumulator #(.PW(16), .SW(18)) u_dut_b (
    .clk(clk), .rst(rst), .Start(Start), .Count(Count),
    .InValid(InValid), .InProduct(InProduct), .InReady(b_ready),
    .Sum(b_sum), .Done(b_done), .Busy(b_busy), .Overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive Start for one edge; optionally record the expected job result.
  task automatic start_job(input logic [7:0] c, input logic [31:0] exp, input bit push);
    Start = 1'b1;
    Count = c;
    if (push) sb.push_back(exp);
    step();
    Start = 1'b0;
    Count = 8'd0;
  endtask

  task automatic send(input logic [15:0] p);
    InValid   = 1'b1;
    InProduct = p;
    step();
    InValid   = 1'b0;
    InProduct = 16'd0;
  endtask

  // Wait (bounded) for Done, then pop the scoreboard and compare Sum.
  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    logic [31:0] exp;
    while (!a_done && k < budget) begin
      step();
      k++;
    end
    if (a_done) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        chk({tag, "_sum"}, {8'd0, a_sum}, exp);
      end
    end else begin
      chk({tag, "_done_timeout"}, {31'd0, a_done}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Count = 8'd0; InValid = 1'b0; InProduct = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_sum",   {8'd0, a_sum}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_done",  {31'd0, a_done}, 32'd0);
    chk("rst_busy",  {31'd0, a_busy}, 32'd0);
    chk("rst_ovf",   {31'd0, a_ovf}, 32'd0);

    // Asynchronous reset in the middle of a cycle while a job is running.
    start_job(8'd2, 32'd0, 1'b0);
    send(16'd50);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_sum",   {8'd0, a_sum}, 32'd0);
    chk("async_rst_busy",  {31'd0, a_busy}, 32'd0);
    chk("async_rst_ready", {31'd0, a_ready}, 32'd0);
    step();
    rst = 1'b0;

    // Basic job: 100+200+300, Done on the 4th cycle after Start.
    start_job(8'd3, 32'd600, 1'b1);
    chk("t1_ready_after_start", {31'd0, a_ready}, 32'd1);
    chk("t1_busy_after_start",  {31'd0, a_busy}, 32'd1);
    send(16'd100);
    send(16'd200);
    send(16'd300);
    chk("t1_done_latency", {31'd0, a_done}, 32'd1);
    wait_done("t1", 0);
    step();
    chk("t1_done_pulse", {31'd0, a_done}, 32'd0);
    chk("t1_busy_clear", {31'd0, a_busy}, 32'd0);
    chk("t1_ready_clear", {31'd0, a_ready}, 32'd0);
    chk("t1_sum_hold", {8'd0, a_sum}, 32'd600);

    // Stalls between two maximal products.
    start_job(8'd2, 32'd131070, 1'b1);
    send(16'd65535);
    for (int i = 0; i < 3; i++) begin
      chk("t2_ready_stall", {31'd0, a_ready}, 32'd1);
      step();
    end
    chk("t2_sum_partial", {8'd0, a_sum}, 32'd65535);
    send(16'd65535);
    chk("t2_done_latency", {31'd0, a_done}, 32'd1);
    wait_done("t2", 0);
    step();

    // Zero-count job.
    start_job(8'd0, 32'd0, 1'b1);
    chk("t3_done_next", {31'd0, a_done}, 32'd1);
    chk("t3_no_ready",  {31'd0, a_ready}, 32'd0);
    wait_done("t3", 0);
    step();

    // Ignored inputs: product in IDLE, Start during ACCUM.
    InValid = 1'b1; InProduct = 16'd7;
    chk("t4_idle_ready", {31'd0, a_ready}, 32'd0);
    step();
    InValid = 1'b0; InProduct = 16'd0;
    chk("t4_idle_sum", {8'd0, a_sum}, 32'd0);
    start_job(8'd2, 32'd30, 1'b1);
    send(16'd10);
    Start = 1'b1; Count = 8'd5;
    step();
    Start = 1'b0; Count = 8'd0;
    chk("t4_busy_after_restart", {31'd0, a_busy}, 32'd1);
    send(16'd20);
    chk("t4_done_latency", {31'd0, a_done}, 32'd1);
    wait_done("t4", 0);
    step();
    start_job(8'd1, 32'd5, 1'b1);
    chk("t4_next_ready", {31'd0, a_ready}, 32'd1);
    send(16'd5);
    wait_done("t4b", 4);
    step();

    // Overflow boundary on the narrow instance: 5 * 65535 = 327675.
    start_job(8'd5, 32'd327675, 1'b1);
    for (int i = 0; i < 5; i++) send(16'd65535);
    chk("t5_b_done", {31'd0, b_done}, 32'd1);
`ifdef PRODUCT_ACC_SATURATE_EN
    chk("t5_b_sum", {14'd0, b_sum}, 32'd262143);
    chk("t5_b_ovf", {31'd0, b_ovf}, 32'd1);
`else
    chk("t5_b_sum", {14'd0, b_sum}, 32'd65531);
    chk("t5_b_ovf", {31'd0, b_ovf}, 32'd0);
`endif
    chk("t5_a_ovf", {31'd0, a_ovf}, 32'd0);
    wait_done("t5", 0);
    step();
`ifdef PRODUCT_ACC_SATURATE_EN
    chk("t5_b_ovf_sticky", {31'd0, b_ovf}, 32'd1);
`endif

    // Reset after two of four transfers: job aborted, no Done.
    start_job(8'd4, 32'd0, 1'b0);
    chk("t6_b_ovf_cleared", {31'd0, b_ovf}, 32'd0);
    send(16'd11);
    send(16'd22);
    chk("t6_sum_partial", {8'd0, a_sum}, 32'd33);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_sum",  {8'd0, a_sum}, 32'd0);
    chk("t6_rst_busy", {31'd0, a_busy}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_done", {31'd0, a_done}, 32'd0);
      step();
    end
    start_job(8'd1, 32'd9, 1'b1);
    send(16'd9);
    wait_done("t6", 4);
    step();
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
